// File: rtl/down_pkg.sv
// down_pkg: frame heads, command codes, run-control states and default timing for the downlink decoder
package down_pkg;
    localparam logic [7:0]  HEAD_LOCK    = 8'hAC;
    localparam logic [7:0]  HEAD_BYPASS  = 8'hA8;
    localparam logic [7:0]  HEAD_DATASYN = 8'hAA;
    localparam logic [7:0]  HEAD_CMD     = 8'hA1;
    localparam logic [7:0]  HEAD_FREQ    = 8'hA2;
    localparam logic [7:0]  HEAD_SW      = 8'hA9;
    localparam logic [15:0] PAY_LOCK     = 16'hECEC;
    localparam logic [15:0] PAY_KEY      = 16'h37A5;
    localparam logic [15:0] CMD_START    = 16'h1111;
    localparam logic [15:0] CMD_STOP     = 16'h2222;
    localparam logic [15:0] CMD_RESET    = 16'h4444;
    localparam int SYNC_PERIOD_DEF = 7999;
    localparam int WDOG_CYCLES_DEF = 40000;
    localparam int CHK_TIMEOUT_DEF = 400000;
    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_CHK, ST_RST} state_t;
endpackage

// File: rtl/down_sync_timer.sv
// down_sync_timer: data-update phase counter; wraps at SYNC_PERIOD or on resync with a one-cycle tick
module down_sync_timer import down_pkg::*; #(
    parameter int SYNC_PERIOD = SYNC_PERIOD_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        resync,
    output logic [12:0] sync_cnt,
    output logic        sync_tick
);
    logic wrap;
    assign wrap = resync || sync_cnt == 13'(SYNC_PERIOD);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            sync_cnt  <= '0;
            sync_tick <= 1'b0;
        end else begin
            sync_tick <= wrap;
            sync_cnt  <= wrap ? '0 : sync_cnt + 13'd1;
        end
endmodule

// File: rtl/down_cmd_decoder.sv
// down_cmd_decoder: downlink frame decoder and run-control FSM for the power unit.
// Define DOWN_WDOG_EN to build the comm-loss watchdog; otherwise comm_lost is tied low.
module down_cmd_decoder import down_pkg::*; #(
    parameter int N_BRG       = 2,
    parameter int N_FLT       = 4,
    parameter int SYNC_PERIOD = SYNC_PERIOD_DEF,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
    parameter int CHK_TIMEOUT = CHK_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               recv_done,
    input  logic [23:0]        recv_data,
    input  logic               fault,
    input  logic [N_FLT-1:0]   igbt_flt,
    input  logic               chkflt_over,
    output logic               start,
    output logic               stop,
    output logic               rst,
    output logic               chkflt,
    output logic               chk_timeout,
    output logic               lockn,
    output logic               bypass_cmd,
    output logic [15:0]        fre_data,
    output logic [2*N_BRG-1:0] reg_igbt,
    output logic               recv_para,
    output logic [12:0]        sync_cnt,
    output logic               sync_tick,
    output logic               comm_lost
);
    localparam int CW = $clog2(CHK_TIMEOUT + 1);
    logic [7:0]  head;
    logic [15:0] pay;
    logic is_lock, is_byp, is_syn, is_cmd, is_freq, is_sw, force_stop, cmd_vld;
    logic [15:0] cmd_pay;
    logic [2*N_BRG-1:0] sw_map;
    logic [CW-1:0] chk_cnt;
    state_t state;
    assign head    = recv_data[23:16];
    assign pay     = recv_data[15:0];
    assign is_lock = recv_done && recv_data == {HEAD_LOCK, PAY_LOCK};
    assign is_byp  = recv_done && recv_data == {HEAD_BYPASS, PAY_KEY};
    assign is_syn  = recv_done && recv_data == {HEAD_DATASYN, PAY_KEY};
    assign is_cmd  = recv_done && head == HEAD_CMD;
    assign is_freq = recv_done && head == HEAD_FREQ;
    assign is_sw   = recv_done && head == HEAD_SW;
    assign recv_para = is_lock || is_cmd || is_sw || is_syn;
    // bridge k takes its lower switch from payload bit k and its upper switch from bit 4+k
    always_comb begin
        sw_map = '0;
        for (int k = 0; k < N_BRG; k++) sw_map[2*k +: 2] = {pay[4+k], pay[k]};
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            cmd_vld    <= 1'b0;
            cmd_pay    <= '0;
            lockn      <= 1'b1;
            bypass_cmd <= 1'b0;
            fre_data   <= '0;
            reg_igbt   <= '0;
        end else begin
            cmd_vld <= is_cmd;
            cmd_pay <= pay;
            if (is_byp) bypass_cmd <= 1'b1;
            if (is_freq && pay != '0) fre_data <= pay;
            if (rst) begin
                lockn    <= 1'b1;
                reg_igbt <= '0;
            end else begin
                if (is_lock) lockn <= 1'b0;
                if (is_sw && pay[15:8] == pay[7:0]) reg_igbt <= sw_map;
            end
        end
`ifdef DOWN_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;
    logic frame_vld;
    assign frame_vld = is_lock || is_byp || is_syn || is_cmd || is_freq || is_sw;
    assign comm_lost = wdog_cnt == WW'(WDOG_CYCLES);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) wdog_cnt <= '0;
        else if (frame_vld) wdog_cnt <= '0;
        else if (!comm_lost) wdog_cnt <= wdog_cnt + WW'(1);
`else
    assign comm_lost = 1'b0;
`endif
    assign force_stop = fault || !lockn || comm_lost;
    assign start  = state == ST_RUN;
    assign stop   = state == ST_STOP;
    assign chkflt = state == ST_CHK;
    assign rst    = state == ST_RST;
    // a reset command while running only stops; rst is issued from STOP alone
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state       <= ST_STOP;
            chk_cnt     <= '0;
            chk_timeout <= 1'b0;
        end else begin
            chk_timeout <= 1'b0;
            case (state)
                ST_STOP:
                    if (cmd_vld && cmd_pay == CMD_START && !force_stop) state <= ST_RUN;
                    else if (cmd_vld && cmd_pay == CMD_RESET) begin
                        state   <= |igbt_flt ? ST_CHK : ST_RST;
                        chk_cnt <= '0;
                    end
                ST_RUN:
                    if (force_stop || (cmd_vld && (cmd_pay == CMD_STOP || cmd_pay == CMD_RESET))) state <= ST_STOP;
                ST_CHK:
                    if (chkflt_over) state <= ST_RST;
                    else if (chk_cnt == CW'(CHK_TIMEOUT - 1)) begin
                        state       <= ST_STOP;
                        chk_timeout <= 1'b1;
                    end else chk_cnt <= chk_cnt + CW'(1);
                default: state <= ST_STOP;
            endcase
        end
    down_sync_timer #(.SYNC_PERIOD(SYNC_PERIOD)) u_sync (
        .clk(clk),
        .rstn(rstn),
        .resync(is_syn),
        .sync_cnt(sync_cnt),
        .sync_tick(sync_tick)
    );
endmodule

// File: tb/tb_down_cmd_decoder.sv
// tb_down_cmd_decoder: random and directed frames against an event-timed reference model of the decoder
module tb_down_cmd_decoder;
    localparam int N_BRG = 2, N_FLT = 4, SP = 7999, WD = 300, CT = 200;
    logic clk = 1'b0, rstn = 1'b0, recv_done = 1'b0, fault = 1'b0, chkflt_over = 1'b0;
    logic [23:0] recv_data = '0;
    logic [N_FLT-1:0] igbt_flt = '0;
    logic start, stop, rst, chkflt, chk_timeout, lockn, bypass_cmd, recv_para, sync_tick, comm_lost;
    logic [15:0] fre_data;
    logic [2*N_BRG-1:0] reg_igbt;
    logic [12:0] sync_cnt;
    always #5 clk = ~clk;
    down_cmd_decoder #(.N_BRG(N_BRG), .N_FLT(N_FLT), .SYNC_PERIOD(SP), .WDOG_CYCLES(WD), .CHK_TIMEOUT(CT)) dut (
        .clk(clk), .rstn(rstn), .recv_done(recv_done), .recv_data(recv_data), .fault(fault),
        .igbt_flt(igbt_flt), .chkflt_over(chkflt_over), .start(start), .stop(stop), .rst(rst),
        .chkflt(chkflt), .chk_timeout(chk_timeout), .lockn(lockn), .bypass_cmd(bypass_cmd),
        .fre_data(fre_data), .reg_igbt(reg_igbt), .recv_para(recv_para), .sync_cnt(sync_cnt),
        .sync_tick(sync_tick), .comm_lost(comm_lost)
    );
    int n_chk = 0, n_err = 0, cyc = 0;
    // model: mode 0 stopped, 1 running, 2 checking, 3 resetting
    int m_mode = 0, chk_entry = 0, last_frame = 0, sync_base = 0;
    bit sync_from_frame = 0, p_vld = 0, m_lockn = 1, m_byp = 0, m_tmo = 0;
    logic [15:0] p_code = '0, m_fre = '0;
    logic [3:0] m_igbt = '0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask
    function automatic bit lost_at(int c);
`ifdef DOWN_WDOG_EN
        return c - last_frame >= WD;
`else
        return 1'b0;
`endif
    endfunction
    function automatic int sync_at(int c);
        return (c - sync_base) % (SP + 1);
    endfunction
    task automatic step(input logic rd, input logic [23:0] d);
        bit lk, bp, sy, cm, fq, sw, frc;
        logic [15:0] pl;
        int nxt;
        check("start", start, m_mode == 1);
        check("stop", stop, m_mode == 0);
        check("chkflt", chkflt, m_mode == 2);
        check("rst", rst, m_mode == 3);
        check("chk_timeout", chk_timeout, m_tmo);
        check("lockn", lockn, m_lockn);
        check("bypass_cmd", bypass_cmd, m_byp);
        check("fre_data", fre_data, m_fre);
        check("reg_igbt", reg_igbt, m_igbt);
        check("sync_cnt", sync_cnt, sync_at(cyc));
        check("sync_tick", sync_tick, sync_at(cyc) == 0 && (cyc > sync_base || sync_from_frame));
        check("comm_lost", comm_lost, lost_at(cyc));
        recv_done = rd;
        recv_data = d;
        pl = d[15:0];
        lk = rd && d == 24'hACECEC;
        bp = rd && d == 24'hA837A5;
        sy = rd && d == 24'hAA37A5;
        cm = rd && d[23:16] == 8'hA1;
        fq = rd && d[23:16] == 8'hA2;
        sw = rd && d[23:16] == 8'hA9;
        #1 check("recv_para", recv_para, lk || cm || sw || sy);
        nxt = cyc + 1;
        frc = fault || !m_lockn || lost_at(cyc);
        m_tmo = 0;
        if (bp) m_byp = 1;
        if (fq && pl != 0) m_fre = pl;
        if (m_mode == 3) begin
            m_lockn = 1;
            m_igbt = 0;
        end else begin
            if (lk) m_lockn = 0;
            if (sw && pl[15:8] == pl[7:0]) m_igbt = {pl[5], pl[1], pl[4], pl[0]};
        end
        case (m_mode)
            0: if (p_vld && p_code == 16'h1111 && !frc) m_mode = 1;
               else if (p_vld && p_code == 16'h4444) begin
                   m_mode = igbt_flt != 0 ? 2 : 3;
                   chk_entry = nxt;
               end
            1: if (frc || (p_vld && (p_code == 16'h2222 || p_code == 16'h4444))) m_mode = 0;
            2: if (chkflt_over) m_mode = 3;
               else if (nxt - chk_entry == CT) begin
                   m_mode = 0;
                   m_tmo = 1;
               end
            default: m_mode = 0;
        endcase
        p_vld = cm;
        p_code = pl;
        if (sy) begin
            sync_base = nxt;
            sync_from_frame = 1;
        end
        if (lk || bp || sy || cm || fq || sw) last_frame = nxt;
        @(posedge clk);
        cyc = nxt;
        @(negedge clk);
    endtask
    task automatic idle(input int n);
        repeat (n) step(1'b0, 24'($urandom));
    endtask
    task automatic frm(input logic [23:0] d);
        step(1'b1, d);
    endtask
    function automatic logic [23:0] rnd_frame();
        logic [7:0] b;
        b = 8'($urandom);
        case ($urandom_range(0, 9))
            0: return 24'hA11111;
            1: return 24'hA12222;
            2: return 24'hA14444;
            3: return {8'hA1, 16'($urandom)};
            4: return {8'hA2, $urandom_range(0, 1) ? 16'h0000 : 16'($urandom)};
            5: return {8'hA9, b, b};
            6: return {8'hA9, 16'($urandom)};
            7: case ($urandom_range(0, 2))
                   0: return 24'hACECEC;
                   1: return 24'hA837A5;
                   default: return 24'hAA37A5;
               endcase
            8: return 24'($urandom);
            default: return {8'hAC, 16'($urandom)};
        endcase
    endfunction
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "time budget expired");
    end
    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        frm(24'hA91111); idle(2);
        frm(24'hA91211); idle(2);
        frm(24'hA20000); frm(24'hA20BB8); idle(1);
        frm(24'hA11111); idle(4);
        fault = 1'b1; idle(2); fault = 1'b0; idle(2);
        frm(24'hA11111); idle(3);
        frm(24'hA14444); idle(3);
        frm(24'hA837A5); idle(1);
        frm(24'hACECEC); idle(1);
        frm(24'hA11111); idle(3);
        igbt_flt = 4'b0010; frm(24'hA14444); idle(5);
        chkflt_over = 1'b1; idle(1); chkflt_over = 1'b0; idle(4);
        frm(24'hA14444); frm(24'hA11111); idle(CT + 5);
        igbt_flt = '0;
        frm(24'hA9FFFF); frm(24'hA14444); idle(1); frm(24'hACECEC); idle(3);
        frm(24'hA9AAAA); frm(24'hA14444); idle(1); frm(24'hA9FFFF); idle(3);
        for (int i = 0; i < 3000; i++) begin
            fault = $urandom_range(0, 49) == 0;
            igbt_flt = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0;
            chkflt_over = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 2) == 0) frm(rnd_frame()); else idle(1);
        end
        fault = 1'b0; igbt_flt = '0; chkflt_over = 1'b0;
        idle(CT + 5);
        while (sync_at(cyc) != 3000) idle(1);
        frm(24'hAA37A5); idle(SP + 10);
        while (sync_at(cyc) != SP) idle(1);
        frm(24'hAA37A5); idle(10);
        frm(24'hA14444); idle(3);
        frm(24'hA11111); idle(3);
        idle(WD + 5);
        frm(24'hA200C8); idle(5);
        frm(24'hA11111); idle(5);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
